// File: rtl/eth_pkg.sv
// Shared Ethernet/XGMII constants, CRC-32 byte step and RX types for the tx and rx MACs.
package eth_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int unsigned ETH_MIN_FRAME = 64;
  localparam int unsigned ETH_MAX_FRAME = 1518;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DRAIN
  } rx_state_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
  } axis_rx_t;

  // One byte of the reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_rx_d32.sv
// Reflected CRC-32 over up to four bytes per cycle (lane 0 first); exposes the raw register.
module crc32_rx_d32 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] data,
  input  logic [3:0]  valid,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 4; i++) begin
      if (valid[i]) crc_next = crc32_byte(crc_next, data[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC32_INIT;
    else if (clr) crc <= CRC32_INIT;
    else          crc <= crc_next;
  end

endmodule

// File: rtl/rx_mac.sv
// XGMII (32-bit) to AXI-Stream receive MAC: preamble/SFD detection, FCS strip and check,
// length and error qualification, abort on an unexpected Start.
module rx_mac import eth_pkg::*; #(
  parameter int unsigned AXIS_DATA_WIDTH  = 32,
  parameter int unsigned XGMII_DATA_WIDTH = 32,
  parameter int unsigned MAX_FRAME_SIZE   = ETH_MAX_FRAME
) (
  input  logic                         rx_clk,
  input  logic                         rx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0]  in_xgmii_data,
  input  logic [XGMII_DATA_WIDTH/8-1:0] in_xgmii_ctl,
  output logic [AXIS_DATA_WIDTH-1:0]   out_master_rx_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] out_master_rx_tkeep,
  output logic                         out_master_rx_tvalid,
  output logic                         out_master_rx_tlast,
  output logic                         out_master_rx_tuser,
  output logic                         out_rx_frame_good,
  output logic                         out_rx_frame_bad
);

  localparam logic [15:0] MIN_LEN    = 16'(ETH_MIN_FRAME);
  localparam logic [15:0] MAX_LEN    = 16'(MAX_FRAME_SIZE);
  localparam logic [31:0] START_WORD = {ETH_PRE, ETH_PRE, ETH_PRE, XGMII_START};
  localparam logic [31:0] SFD_WORD   = {ETH_SFD, ETH_PRE, ETH_PRE, ETH_PRE};

  rx_state_t   state;
  logic [31:0] d0, d1;
  logic        v0, v1;
  logic [15:0] cnt;
  logic        err;
  logic [3:0]  tail_keep;
  axis_rx_t    axis;
  logic        good, bad;

  logic        is_start, start_word, sfd_word;
  logic        term_any, fe_any, ctl_err, err_now, frame_ok;
  logic [1:0]  term_lane;
  logic [3:0]  below;
  logic [2:0]  len_add;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;
  logic [31:0] crc;
  logic        crc_clr;
  logic [3:0]  crc_valid;

  // Decode of the current XGMII word.
  always_comb begin
    is_start   = in_xgmii_ctl[0] && (in_xgmii_data[7:0] == XGMII_START);
    start_word = (in_xgmii_data == START_WORD) && (in_xgmii_ctl == 4'b0001);
    sfd_word   = (in_xgmii_data == SFD_WORD) && (in_xgmii_ctl == 4'b0000);
    term_any   = 1'b0;
    term_lane  = 2'd0;
    fe_any     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (in_xgmii_ctl[i] && (in_xgmii_data[8*i +: 8] == XGMII_TERM)) begin
        term_any  = 1'b1;
        term_lane = 2'(i);
      end
      if (in_xgmii_ctl[i] && (in_xgmii_data[8*i +: 8] == XGMII_ERROR)) fe_any = 1'b1;
    end
    case (term_lane)
      2'd0:    below = 4'b0000;
      2'd1:    below = 4'b0001;
      2'd2:    below = 4'b0011;
      default: below = 4'b0111;
    endcase
    // Idle lanes after the terminate are legal; control in a data lane is not.
    ctl_err  = term_any ? |(in_xgmii_ctl & below) : |in_xgmii_ctl;
    err_now  = ctl_err | fe_any;
    len_add  = term_any ? {1'b0, term_lane} : 3'd4;
    cnt_sum  = {1'b0, cnt} + {14'd0, len_add};
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    frame_ok = (crc == CRC32_RESIDUE) && (cnt >= MIN_LEN) && (cnt <= MAX_LEN);
    crc_clr  = (state != DATA);
    crc_valid = 4'b0000;
    if (state == DATA && !is_start) crc_valid = term_any ? below : 4'b1111;
  end

  crc32_rx_d32 u_crc (
    .clk   (rx_clk),
    .rst   (rx_rst),
    .clr   (crc_clr),
    .data  (in_xgmii_data),
    .valid (crc_valid),
    .crc   (crc)
  );

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state     <= IDLE;
      d0        <= '0;
      d1        <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      tail_keep <= '0;
      axis      <= '0;
      good      <= 1'b0;
      bad       <= 1'b0;
    end else begin
      axis.tvalid <= 1'b0;
      axis.tlast  <= 1'b0;
      axis.tuser  <= 1'b0;
      good        <= 1'b0;
      bad         <= 1'b0;
      case (state)
        IDLE: if (start_word) state <= PREAMBLE;

        PREAMBLE: begin
          if (sfd_word) begin
            state <= DATA;
            v0    <= 1'b0;
            v1    <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        DATA: begin
          if (is_start) begin
            // Abort: flush the oldest held word as a bad last beat, drop the rest.
            state <= IDLE;
            v0    <= 1'b0;
            v1    <= 1'b0;
            bad   <= 1'b1;
            if (v1 || v0) begin
              axis.tdata  <= v1 ? d1 : d0;
              axis.tkeep  <= 4'b1111;
              axis.tvalid <= 1'b1;
              axis.tlast  <= 1'b1;
              axis.tuser  <= 1'b1;
            end
          end else if (term_any) begin
            state     <= DRAIN;
            cnt       <= cnt_next;
            err       <= err | err_now;
            tail_keep <= below;
            if (term_lane == 2'd0) begin
              // Previous word is all FCS, so the word before it is the last beat now.
              v0 <= 1'b0;
              v1 <= 1'b0;
              if (v1) begin
                axis.tdata  <= d1;
                axis.tkeep  <= 4'b1111;
                axis.tvalid <= 1'b1;
                axis.tlast  <= 1'b1;
                axis.tuser  <= !(frame_ok && !err && !err_now);
              end
              good <= v1 && frame_ok && !err && !err_now;
              bad  <= !(v1 && frame_ok && !err && !err_now);
            end else begin
              d1 <= d0;
              v1 <= v0;
              v0 <= 1'b0;
              if (v1) begin
                axis.tdata  <= d1;
                axis.tkeep  <= 4'b1111;
                axis.tvalid <= 1'b1;
              end
            end
          end else begin
            d0  <= in_xgmii_data;
            v0  <= 1'b1;
            d1  <= d0;
            v1  <= v0;
            cnt <= cnt_next;
            err <= err | err_now;
            if (v1) begin
              axis.tdata  <= d1;
              axis.tkeep  <= 4'b1111;
              axis.tvalid <= 1'b1;
            end
          end
        end

        DRAIN: begin
          // Partial final beat once the trailing FCS bytes are in the CRC.
          state <= IDLE;
          v0    <= 1'b0;
          v1    <= 1'b0;
          if (v1) begin
            axis.tdata  <= d1;
            axis.tkeep  <= tail_keep;
            axis.tvalid <= 1'b1;
            axis.tlast  <= 1'b1;
            axis.tuser  <= !(frame_ok && !err);
          end
          if (tail_keep != 4'b0000) begin
            good <= v1 && frame_ok && !err;
            bad  <= !(v1 && frame_ok && !err);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign out_master_rx_tdata  = axis.tdata;
  assign out_master_rx_tkeep  = axis.tkeep;
  assign out_master_rx_tvalid = axis.tvalid;
  assign out_master_rx_tlast  = axis.tlast;
  assign out_master_rx_tuser  = axis.tuser;
  assign out_rx_frame_good    = good;
  assign out_rx_frame_bad     = bad;

endmodule
